e603_gnrl_cdc_tx: RTL and testbench

E603_GNRL_CDC_TX -- requirements
Module: e603_gnrl_cdc_tx

---
 rtl/e603_gnrl_cdc_tx_pkg.sv | 14 +
 rtl/e603_gnrl_tech_sync.sv | 31 +++
 rtl/e603_gnrl_cdc_tx.sv | 108 ++++++++++
 tb/tb_e603_gnrl_cdc_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e603_gnrl_cdc_tx_pkg.sv
// Shared definitions for the e603 CDC transmit side.
// Holds the FSM state encoding used by e603_gnrl_cdc_tx.
package e603_gnrl_cdc_tx_pkg;

  localparam int unsigned CDC_TX_ST_W = 2;

  // Transmit handshake states: idle, request raised, waiting for ack to fall
  typedef enum logic [CDC_TX_ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKLO = 2'd2
  } cdc_tx_state_e;

endpackage

// File: rtl/e603_gnrl_tech_sync.sv
// Multi-flop synchronizer for signals arriving from another clock domain.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, loads RST_VAL into every stage
//   din_a  asynchronous input
//   dout   synchronized output (last stage)
module e603_gnrl_tech_sync #(
  parameter int unsigned        DP      = 2,
  parameter int unsigned        DW      = 1,
  parameter logic [DW-1:0]      RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout
);

  logic [DP-1:0][DW-1:0] sync_q;

  // Shift chain; stage 0 captures the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DP{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DP-2:0], din_a};
    end
  end

  assign dout = sync_q[DP-1];

endmodule

// File: rtl/e603_gnrl_cdc_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing.
// A word accepted on i_vld/i_rdy is held on o_dat while o_req is raised; the
// destination acknowledges via i_ack_a, which is synchronized before use.
// Ports:
//   clk, rst   source clock, asynchronous active-high reset
//   i_vld      word offered          i_rdy  word accepted this cycle
//   i_dat      offered word
//   o_req      request to destination (flop)
//   o_dat      held word to destination (flop)
//   i_ack_a    asynchronous acknowledge from destination
//   o_done     one-cycle pulse on handshake completion
//   o_busy     high whenever the FSM is not idle
module e603_gnrl_cdc_tx
  import e603_gnrl_cdc_tx_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned SYNC_DP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_req,
  output logic [DW-1:0] o_dat,
  input  logic          i_ack_a,
  output logic          o_done,
  output logic          o_busy
);

  cdc_tx_state_e state;
  cdc_tx_state_e state_nxt;
  logic          req_nxt;
  logic [DW-1:0] dat_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          ack_s;
  logic          rst_n;

  assign rst_n = ~rst;

  // Bring the destination acknowledge into the source clock domain
  e603_gnrl_tech_sync #(
    .DP      (SYNC_DP),
    .DW      (1),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din_a (i_ack_a),
    .dout  (ack_s)
  );

  // Ready only in idle with the ack fully released (blocks a stale/spurious ack)
  assign i_rdy = (state == ST_IDLE) & ~ack_s;

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    req_nxt   = o_req;
    dat_nxt   = o_dat;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_vld && i_rdy) begin
          dat_nxt   = i_dat;
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = ST_ACKLO;
        end
      end
      ST_ACKLO: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output flops; reset drops o_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      o_req  <= 1'b0;
      o_dat  <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_req  <= req_nxt;
      o_dat  <= dat_nxt;
      o_done <= done_nxt;
      o_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_e603_gnrl_cdc_tx.sv
// Self-checking bench for e603_gnrl_cdc_tx with a randomized destination responder.
module tb_e603_gnrl_cdc_tx;

  localparam int unsigned DW      = 32;
  localparam int unsigned SYNC_DP = 2;
  localparam int          NTR     = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_req;
  logic [DW-1:0] o_dat;
  logic          i_ack_a;
  logic          o_done;
  logic          o_busy;

  logic man_ack;
  logic resp_ack;
  bit   resp_en = 1'b0;
  int   dmax    = 3;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] exp_q[$];

  assign i_ack_a = resp_en ? resp_ack : man_ack;

  always #5 clk = ~clk;

  e603_gnrl_cdc_tx #(
    .DW      (DW),
    .SYNC_DP (SYNC_DP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (i_vld),
    .i_rdy   (i_rdy),
    .i_dat   (i_dat),
    .o_req   (o_req),
    .o_dat   (o_dat),
    .i_ack_a (i_ack_a),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  // Destination responder: random delay before raising ack (sampling o_dat)
  // and before dropping it again.
  initial begin
    int pend;
    pend     = -1;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        pend     = -1;
        resp_ack = 1'b0;
      end else if (!resp_ack) begin
        if (o_req) begin
          if (pend < 0) pend = int'($urandom_range(dmax, 0));
          if (pend == 0) begin
            cap_q.push_back(o_dat);
            resp_ack = 1'b1;
            pend     = -1;
          end else pend--;
        end
      end else begin
        if (!o_req) begin
          if (pend < 0) pend = int'($urandom_range(dmax, 0));
          if (pend == 0) begin
            resp_ack = 1'b0;
            pend     = -1;
          end else pend--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    i_vld   = 1'b0;
    i_dat   = '0;
    man_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_req, o_done, o_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: req/done/busy=%b expected 000", {o_req, o_done, o_busy});
    end
    checks++;
    if (o_dat !== '0) begin
      errors++;
      $display("FAIL reset_o_dat: got %h expected 0", o_dat);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (i_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_i_rdy: got %b expected 1", i_rdy);
    end
  endtask

  // Fixed-timing transfer: ack up at cycle 3, down at cycle 7
  task automatic test_basic();
    logic exp_req, exp_done, exp_busy;
    i_dat = 32'hA5A5_0001;
    i_vld = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) i_vld = 1'b0;
      if (c == 3) man_ack = 1'b1;
      if (c == 7) man_ack = 1'b0;
      exp_req  = (c >= 1 && c <= 5);
      exp_done = (c == 10);
      exp_busy = (c >= 1 && c <= 9);
      checks++;
      if ({o_req, o_done, o_busy} !== {exp_req, exp_done, exp_busy}) begin
        errors++;
        $display("FAIL basic_cycle%0d: req/done/busy=%b expected %b", c,
                 {o_req, o_done, o_busy}, {exp_req, exp_done, exp_busy});
      end
      if (c == 1) begin
        checks++;
        if (o_dat !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL basic_o_dat: got %h expected a5a50001", o_dat);
        end
      end
    end
    checks++;
    if (i_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_rdy_after: got %b expected 1", i_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int  nacc, ndone, lc, done_c, rise2_c;
    bit  acc, prev_req;
    cap_q.delete();
    dmax     = 3;
    resp_en  = 1'b1;
    nacc     = 0;
    ndone    = 0;
    done_c   = -1;
    rise2_c  = -1;
    prev_req = o_req;
    i_dat    = 32'h1;
    i_vld    = 1'b1;
    for (lc = 0; lc < 300 && ndone < 2; lc++) begin
      acc = i_vld && i_rdy;
      if (acc) nacc++;
      tick();
      if (acc) begin
        if (nacc == 1) i_dat = 32'h2;
        else i_vld = 1'b0;
      end
      if (o_req && !prev_req && nacc == 2 && rise2_c < 0) rise2_c = lc;
      if (o_done) begin
        ndone++;
        if (done_c < 0) done_c = lc;
      end
      prev_req = o_req;
    end
    i_vld   = 1'b0;
    resp_en = 1'b0;
    checks++;
    if (ndone !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", ndone);
    end
    checks++;
    if (rise2_c !== done_c + 1) begin
      errors++;
      $display("FAIL b2b_spacing: second req at %0d expected %0d", rise2_c, done_c + 1);
    end
    checks++;
    if (cap_q.size() !== 2 || cap_q[0] !== 32'h1 || cap_q[1] !== 32'h2) begin
      errors++;
      $display("FAIL b2b_order: got %0d words (%h,%h) expected 2 words (1,2)",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : '0,
               (cap_q.size() > 1) ? cap_q[1] : '0);
    end
    tick();
  endtask

  task automatic test_data_stability();
    logic [DW-1:0] word;
    bit            seen;
    word  = $urandom;
    i_dat = word;
    i_vld = 1'b1;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (o_done) begin
        seen  = 1'b1;
        i_vld = 1'b0;
      end else begin
        checks++;
        if (o_dat !== word || i_rdy !== 1'b0) begin
          errors++;
          $display("FAIL stability_k%0d: o_dat=%h i_rdy=%b expected %h / 0", k, o_dat, i_rdy, word);
        end
        i_dat = $urandom;
        if (k == 2) man_ack = 1'b1;
        if (k == 8) man_ack = 1'b0;
        tick();
      end
    end
    i_vld = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stability_done: got no o_done expected one within 40 cycles");
    end
    tick();
  endtask

  task automatic test_spurious();
    logic [DW-1:0] word;
    bit            seen;
    man_ack = 1'b1;
    repeat (3) tick();
    word  = $urandom;
    i_dat = word;
    i_vld = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({o_req, o_done, o_busy, i_rdy} !== 4'b0000) begin
        errors++;
        $display("FAIL spurious_k%0d: req/done/busy/rdy=%b expected 0000", k,
                 {o_req, o_done, o_busy, i_rdy});
      end
    end
    man_ack = 1'b0;
    for (int j = 1; j <= SYNC_DP + 1; j++) begin
      tick();
      checks++;
      if (o_req !== (j == SYNC_DP + 1)) begin
        errors++;
        $display("FAIL spurious_accept_j%0d: o_req=%b expected %b", j, o_req, (j == SYNC_DP + 1));
      end
    end
    i_vld = 1'b0;
    cap_q.delete();
    dmax    = 4;
    resp_en = 1'b1;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    resp_en = 1'b0;
    checks++;
    if (!seen || cap_q.size() !== 1 || cap_q[0] !== word) begin
      errors++;
      $display("FAIL spurious_word: done=%b words=%0d expected done with word %h", seen, cap_q.size(), word);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    i_dat = $urandom;
    i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
    tick();
    man_ack = 1'b1;
    tick();
    checks++;
    if (o_req !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: o_req=%b expected 1", o_req);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_req, o_busy} !== 2'b00 || o_dat !== '0) begin
      errors++;
      $display("FAIL midrst_async: req/busy=%b o_dat=%h expected 00 / 0", {o_req, o_busy}, o_dat);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (SYNC_DP + 1) tick();
    i_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({i_rdy, o_req} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_hold_k%0d: rdy/req=%b expected 00", k, {i_rdy, o_req});
      end
    end
    man_ack = 1'b0;
    for (int j = 1; j <= SYNC_DP + 1; j++) begin
      tick();
      checks++;
      if (o_req !== (j == SYNC_DP + 1)) begin
        errors++;
        $display("FAIL midrst_accept_j%0d: o_req=%b expected %b", j, o_req, (j == SYNC_DP + 1));
      end
    end
    i_vld   = 1'b0;
    resp_en = 1'b1;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    resp_en = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_complete: got no o_done expected one");
    end
    tick();
  endtask

  task automatic test_random();
    int  n_acc, n_done, guard, nbad;
    bit  have, acc, prev_done, prev_req;
    cap_q.delete();
    exp_q.delete();
    dmax      = 20;
    resp_en   = 1'b1;
    n_acc     = 0;
    n_done    = 0;
    guard     = 0;
    have      = 1'b0;
    prev_done = o_done;
    prev_req  = o_req;
    while (n_done < NTR && guard < 80000) begin
      guard++;
      if (!have && n_acc < NTR && $urandom_range(1, 0) == 1) begin
        i_dat = $urandom;
        i_vld = 1'b1;
        have  = 1'b1;
      end
      acc = have && i_rdy;
      if (acc) begin
        exp_q.push_back(i_dat);
        n_acc++;
      end
      tick();
      if (acc) begin
        i_vld = 1'b0;
        have  = 1'b0;
      end
      if (o_done) n_done++;
      checks++;
      if ((o_done && prev_done) || (i_rdy && o_busy)) begin
        errors++;
        $display("FAIL random_protocol_cyc%0d: done/prev_done/rdy/busy=%b expected no double done, no rdy while busy",
                 guard, {o_done, prev_done, i_rdy, o_busy});
      end
      if (o_req && !prev_req) begin
        checks++;
        if (exp_q.size() == 0 || o_dat !== exp_q[exp_q.size()-1]) begin
          errors++;
          $display("FAIL random_o_dat_cyc%0d: got %h expected last accepted word", guard, o_dat);
        end
      end
      prev_done = o_done;
      prev_req  = o_req;
    end
    i_vld   = 1'b0;
    resp_en = 1'b0;
    checks++;
    if (n_done !== NTR || n_acc !== NTR) begin
      errors++;
      $display("FAIL random_counts: done=%0d accepted=%0d expected %0d each", n_done, n_acc, NTR);
    end
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_word_count: got %0d delivered expected %0d", cap_q.size(), exp_q.size());
    end
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        nbad++;
        if (nbad <= 10)
          $display("FAIL random_word%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_data_stability();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
